// File: rtl/snitch_icache_pkg.sv
// Shared widths and types for the icache refill handler.
package snitch_icache_pkg;

    localparam int FETCH_AW      = 32;
    localparam int LINE_WIDTH    = 128;
    localparam int ID_WIDTH      = 4;
    localparam int SET_COUNT     = 2;
    localparam int LINE_COUNT    = 64;
    localparam int PENDING_COUNT = 4;

    localparam int SET_ALIGN   = $clog2(SET_COUNT);
    localparam int COUNT_ALIGN = $clog2(LINE_COUNT);
    localparam int PID_WIDTH   = $clog2(PENDING_COUNT);
    localparam int LINE_ALIGN  = $clog2(LINE_WIDTH / 8);
    localparam int TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN;
    localparam int LINE_AW     = FETCH_AW - LINE_ALIGN;

    typedef logic [LINE_AW-1:0] line_addr_t;

    typedef struct packed {
        line_addr_t          line_addr;
        logic [ID_WIDTH-1:0] id_mask;
        logic                valid;
    } pending_entry_t;

    typedef struct packed {
        logic [FETCH_AW-1:0]  addr;
        logic [PID_WIDTH-1:0] id;
    } refill_req_t;

    // Cache-line address of a fetch address.
    function automatic line_addr_t line_of(input logic [FETCH_AW-1:0] addr);
        return addr[FETCH_AW-1:LINE_ALIGN];
    endfunction

endpackage

// File: rtl/snitch_icache_refill_handler_if.sv
// Bus bundle between lookup stage, fetch ports, refill bus and lookup write port.
interface snitch_icache_refill_handler_if;
    import snitch_icache_pkg::*;

    logic                   flush_valid_i;
    logic                   flush_ready_o;

    logic [FETCH_AW-1:0]    in_addr_i;
    logic [ID_WIDTH-1:0]    in_id_i;
    logic [SET_ALIGN-1:0]   in_set_i;
    logic                   in_hit_i;
    logic [LINE_WIDTH-1:0]  in_data_i;
    logic                   in_error_i;
    logic                   in_valid_i;
    logic                   in_ready_o;

    logic [LINE_WIDTH-1:0]  rsp_data_o;
    logic                   rsp_error_o;
    logic [ID_WIDTH-1:0]    rsp_id_o;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i;

    logic [FETCH_AW-1:0]    refill_qaddr_o;
    logic [PID_WIDTH-1:0]   refill_qid_o;
    logic                   refill_qvalid_o;
    logic                   refill_qready_i;

    logic [LINE_WIDTH-1:0]  refill_pdata_i;
    logic                   refill_perror_i;
    logic [PID_WIDTH-1:0]   refill_pid_i;
    logic                   refill_pvalid_i;
    logic                   refill_pready_o;

    logic [COUNT_ALIGN-1:0] write_addr_o;
    logic [SET_ALIGN-1:0]   write_set_o;
    logic [LINE_WIDTH-1:0]  write_data_o;
    logic [TAG_WIDTH-1:0]   write_tag_o;
    logic                   write_error_o;
    logic                   write_valid_o;
    logic                   write_ready_i;

    // Handler side.
    modport master (
        input  flush_valid_i, in_addr_i, in_id_i, in_set_i, in_hit_i, in_data_i,
               in_error_i, in_valid_i, rsp_ready_i, refill_qready_i, refill_pdata_i,
               refill_perror_i, refill_pid_i, refill_pvalid_i, write_ready_i,
        output flush_ready_o, in_ready_o, rsp_data_o, rsp_error_o, rsp_id_o, rsp_valid_o,
               refill_qaddr_o, refill_qid_o, refill_qvalid_o, refill_pready_o,
               write_addr_o, write_set_o, write_data_o, write_tag_o, write_error_o,
               write_valid_o
    );

    // Environment side.
    modport slave (
        output flush_valid_i, in_addr_i, in_id_i, in_set_i, in_hit_i, in_data_i,
               in_error_i, in_valid_i, rsp_ready_i, refill_qready_i, refill_pdata_i,
               refill_perror_i, refill_pid_i, refill_pvalid_i, write_ready_i,
        input  flush_ready_o, in_ready_o, rsp_data_o, rsp_error_o, rsp_id_o, rsp_valid_o,
               refill_qaddr_o, refill_qid_o, refill_qvalid_o, refill_pready_o,
               write_addr_o, write_set_o, write_data_o, write_tag_o, write_error_o,
               write_valid_o
    );

endinterface

// File: rtl/snitch_icache_pending_table.sv
// Pending-miss table: line match, lowest-free allocation, mask merge, free.
module snitch_icache_pending_table
    import snitch_icache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  line_addr_t           lookup_line,
    output logic                 match,
    output logic [PID_WIDTH-1:0] match_pid,
    output logic                 avail,
    output logic [PID_WIDTH-1:0] alloc_pid,
    input  logic                 alloc_en,
    input  logic [ID_WIDTH-1:0]  alloc_mask,
    input  logic                 merge_en,
    input  logic [ID_WIDTH-1:0]  merge_mask,
    input  logic                 free_en,
    input  logic [PID_WIDTH-1:0] free_pid,
    output pending_entry_t       free_entry,
    output logic                 any_valid
);

    pending_entry_t [PENDING_COUNT-1:0] entries;
    logic [PENDING_COUNT-1:0]           live;

    // Entries being freed this cycle can neither be matched nor reused.
    always_comb begin
        live = '0;
        for (int i = 0; i < PENDING_COUNT; i++)
            live[i] = entries[i].valid && !(free_en && free_pid == PID_WIDTH'(i));
    end

    // Match search and lowest-free pick (descending loop leaves the lowest index).
    always_comb begin
        match     = 1'b0;
        match_pid = '0;
        avail     = 1'b0;
        alloc_pid = '0;
        any_valid = 1'b0;
        for (int i = PENDING_COUNT - 1; i >= 0; i--) begin
            if (live[i] && entries[i].line_addr == lookup_line) begin
                match     = 1'b1;
                match_pid = PID_WIDTH'(i);
            end
            if (!entries[i].valid) begin
                avail     = 1'b1;
                alloc_pid = PID_WIDTH'(i);
            end
            if (entries[i].valid) any_valid = 1'b1;
        end
    end

    assign free_entry = entries[free_pid];

    // Entry storage updates; free, merge and allocate never target the same entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            entries <= '0;
        end else begin
            for (int i = 0; i < PENDING_COUNT; i++) begin
                if (free_en && free_pid == PID_WIDTH'(i))
                    entries[i].valid <= 1'b0;
                if (merge_en && match_pid == PID_WIDTH'(i))
                    entries[i].id_mask <= entries[i].id_mask | merge_mask;
                if (alloc_en && alloc_pid == PID_WIDTH'(i)) begin
                    entries[i].line_addr <= lookup_line;
                    entries[i].id_mask   <= alloc_mask;
                    entries[i].valid     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/snitch_icache_refill_handler.sv
// Icache refill handler: forwards hits, coalesces misses per line, issues
// refills and writes returned lines back to the lookup stage.
// Optional: define SNITCH_ICACHE_REFILL_PERF_EN for hit/miss/coalesce counters.
module snitch_icache_refill_handler
    import snitch_icache_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    snitch_icache_refill_handler_if.master bus
`ifdef SNITCH_ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]                   perf_hit_o,
    output logic [31:0]                   perf_miss_o,
    output logic [31:0]                   perf_coalesce_o
`endif
);

    line_addr_t           lookup_line;
    logic                 match, avail, alloc_en, merge_en, any_valid;
    logic [PID_WIDTH-1:0] match_pid, alloc_pid;
    pending_entry_t       free_entry;
    logic                 commit, hit_fire;
    refill_req_t          req_q;
    logic                 req_valid_q;
    logic [SET_ALIGN-1:0] repl_q;
    logic                 unused_bits;

    assign lookup_line = line_of(bus.in_addr_i);
    assign unused_bits = ^{bus.in_addr_i[LINE_ALIGN-1:0], bus.in_set_i, bus.flush_valid_i};

    snitch_icache_pending_table i_table (
        .clk         (clk_i),
        .rst         (rst_i),
        .lookup_line (lookup_line),
        .match       (match),
        .match_pid   (match_pid),
        .avail       (avail),
        .alloc_pid   (alloc_pid),
        .alloc_en    (alloc_en),
        .alloc_mask  (bus.in_id_i),
        .merge_en    (merge_en),
        .merge_mask  (bus.in_id_i),
        .free_en     (commit),
        .free_pid    (bus.refill_pid_i),
        .free_entry  (free_entry),
        .any_valid   (any_valid)
    );

    // A response for a live entry needs both the write port and the fetch port;
    // a response for a dead entry (stale across reset) is simply swallowed.
    assign commit = bus.refill_pvalid_i && free_entry.valid &&
                    bus.write_ready_i && bus.rsp_ready_i;
    assign bus.refill_pready_o = bus.refill_pvalid_i &&
                                 (!free_entry.valid || (bus.write_ready_i && bus.rsp_ready_i));

    assign bus.write_addr_o  = free_entry.line_addr[COUNT_ALIGN-1:0];
    assign bus.write_tag_o   = free_entry.line_addr[LINE_AW-1:COUNT_ALIGN];
    assign bus.write_set_o   = repl_q;
    assign bus.write_data_o  = bus.refill_pdata_i;
    assign bus.write_error_o = bus.refill_perror_i;

    assign bus.refill_qvalid_o = req_valid_q;
    assign bus.refill_qaddr_o  = req_q.addr;
    assign bus.refill_qid_o    = req_q.id;
    assign bus.flush_ready_o   = !any_valid && !req_valid_q;

    // Response mux (refill beats hit) and miss merge/allocate decision.
    always_comb begin
        bus.rsp_valid_o   = 1'b0;
        bus.rsp_data_o    = bus.in_data_i;
        bus.rsp_error_o   = bus.in_error_i;
        bus.rsp_id_o      = bus.in_id_i;
        bus.in_ready_o    = 1'b0;
        bus.write_valid_o = 1'b0;
        alloc_en          = 1'b0;
        merge_en          = 1'b0;
        hit_fire          = 1'b0;
        if (commit) begin
            bus.write_valid_o = 1'b1;
            bus.rsp_valid_o   = 1'b1;
            bus.rsp_data_o    = bus.refill_pdata_i;
            bus.rsp_error_o   = bus.refill_perror_i;
            bus.rsp_id_o      = free_entry.id_mask;
        end
        if (bus.in_valid_i) begin
            if (bus.in_hit_i) begin
                if (!commit) begin
                    bus.rsp_valid_o = 1'b1;
                    bus.in_ready_o  = bus.rsp_ready_i;
                    hit_fire        = bus.rsp_ready_i;
                end
            end else if (match) begin
                merge_en       = 1'b1;
                bus.in_ready_o = 1'b1;
            end else if (avail && (!req_valid_q || bus.refill_qready_i)) begin
                alloc_en       = 1'b1;
                bus.in_ready_o = 1'b1;
            end
        end
    end

    // Refill request register and round-robin victim set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_valid_q <= 1'b0;
            req_q       <= '0;
            repl_q      <= '0;
        end else begin
            if (alloc_en) begin
                req_valid_q <= 1'b1;
                req_q.addr  <= {lookup_line, {LINE_ALIGN{1'b0}}};
                req_q.id    <= alloc_pid;
            end else if (bus.refill_qready_i) begin
                req_valid_q <= 1'b0;
            end
            if (commit)
                repl_q <= (repl_q == SET_ALIGN'(SET_COUNT - 1)) ? '0 : repl_q + SET_ALIGN'(1);
        end
    end

`ifdef SNITCH_ICACHE_REFILL_PERF_EN
    logic perf_clr;
    assign perf_clr = bus.flush_valid_i && bus.flush_ready_o;

    // Saturating event counters, cleared by an accepted flush.
    always_ff @(posedge clk_i) begin
        if (rst_i || perf_clr) begin
            perf_hit_o      <= '0;
            perf_miss_o     <= '0;
            perf_coalesce_o <= '0;
        end else begin
            if (hit_fire && perf_hit_o != '1)      perf_hit_o      <= perf_hit_o + 32'd1;
            if (alloc_en && perf_miss_o != '1)     perf_miss_o     <= perf_miss_o + 32'd1;
            if (merge_en && perf_coalesce_o != '1) perf_coalesce_o <= perf_coalesce_o + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = hit_fire;
`endif

endmodule

// File: tb/tb_snitch_icache_refill_handler.sv
// Directed self-checking bench for snitch_icache_refill_handler.
module tb_snitch_icache_refill_handler;
    import snitch_icache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snitch_icache_refill_handler_if bus ();

`ifdef SNITCH_ICACHE_REFILL_PERF_EN
    logic [31:0] perf_hit, perf_miss, perf_coalesce;
`endif

    snitch_icache_refill_handler dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef SNITCH_ICACHE_REFILL_PERF_EN
        ,
        .perf_hit_o      (perf_hit),
        .perf_miss_o     (perf_miss),
        .perf_coalesce_o (perf_coalesce)
`endif
    );

    int checks = 0;
    int failures = 0;

    localparam logic [LINE_WIDTH-1:0] HIT_DATA = {4{32'hCAFE_0001}};
    localparam logic [LINE_WIDTH-1:0] REF_DATA = {4{32'h1234_ABCD}};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush_valid_i   = 1'b0;
        bus.in_addr_i       = '0;
        bus.in_id_i         = '0;
        bus.in_set_i        = '0;
        bus.in_hit_i        = 1'b0;
        bus.in_data_i       = '0;
        bus.in_error_i      = 1'b0;
        bus.in_valid_i      = 1'b0;
        bus.rsp_ready_i     = 1'b1;
        bus.refill_qready_i = 1'b0;
        bus.refill_pdata_i  = '0;
        bus.refill_perror_i = 1'b0;
        bus.refill_pid_i    = '0;
        bus.refill_pvalid_i = 1'b0;
        bus.write_ready_i   = 1'b1;
    endtask

    task automatic miss(input logic [FETCH_AW-1:0] a, input logic [ID_WIDTH-1:0] id);
        bus.in_valid_i = 1'b1;
        bus.in_hit_i   = 1'b0;
        bus.in_addr_i  = a;
        bus.in_id_i    = id;
    endtask

    task automatic refill(input logic [PID_WIDTH-1:0] pid);
        bus.refill_pvalid_i = 1'b1;
        bus.refill_pid_i    = pid;
        bus.refill_pdata_i  = REF_DATA;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.rsp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0h exp=0", bus.rsp_valid_o); end
        checks++; if (bus.refill_qvalid_o !== 1'b0) begin failures++; $display("FAIL reset_qvalid got=%0h exp=0", bus.refill_qvalid_o); end
        checks++; if (bus.write_valid_o !== 1'b0) begin failures++; $display("FAIL reset_write_valid got=%0h exp=0", bus.write_valid_o); end
        checks++; if (bus.refill_pready_o !== 1'b0) begin failures++; $display("FAIL reset_pready got=%0h exp=0", bus.refill_pready_o); end
        checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0h exp=0", bus.in_ready_o); end
        checks++; if (bus.flush_ready_o !== 1'b1) begin failures++; $display("FAIL reset_flush_ready got=%0h exp=1", bus.flush_ready_o); end
    endtask

    task automatic test_hit();
        do_reset();
        bus.in_valid_i = 1'b1; bus.in_hit_i = 1'b1; bus.in_addr_i = 32'h1000;
        bus.in_id_i = 4'b0001; bus.in_data_i = HIT_DATA;
        #1;
        checks++; if (bus.rsp_valid_o !== 1'b1) begin failures++; $display("FAIL hit_rsp_valid got=%0h exp=1", bus.rsp_valid_o); end
        checks++; if (bus.rsp_id_o !== 4'b0001) begin failures++; $display("FAIL hit_rsp_id got=%0h exp=1", bus.rsp_id_o); end
        checks++; if (bus.rsp_data_o !== HIT_DATA) begin failures++; $display("FAIL hit_rsp_data got=%0h exp=%0h", bus.rsp_data_o, HIT_DATA); end
        checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL hit_in_ready got=%0h exp=1", bus.in_ready_o); end
        bus.rsp_ready_i = 1'b0;
        #1;
        checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL hit_backpressure got=%0h exp=0", bus.in_ready_o); end
        bus.rsp_ready_i = 1'b1;
        step();
        idle();
        #1;
        checks++; if (bus.refill_qvalid_o !== 1'b0) begin failures++; $display("FAIL hit_no_refill got=%0h exp=0", bus.refill_qvalid_o); end
    endtask

    task automatic test_coalesce();
        do_reset();
        miss(32'h2000, 4'b0010);
        #1;
        checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL co_first_ready got=%0h exp=1", bus.in_ready_o); end
        step();
        miss(32'h2004, 4'b0001);
        #1;
        checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL co_second_ready got=%0h exp=1", bus.in_ready_o); end
        checks++; if (bus.refill_qvalid_o !== 1'b1) begin failures++; $display("FAIL co_qvalid got=%0h exp=1", bus.refill_qvalid_o); end
        checks++; if (bus.refill_qaddr_o !== 32'h2000) begin failures++; $display("FAIL co_qaddr got=%0h exp=2000", bus.refill_qaddr_o); end
        checks++; if (bus.refill_qid_o !== 2'd0) begin failures++; $display("FAIL co_qid got=%0h exp=0", bus.refill_qid_o); end
        step();
        idle();
        bus.refill_qready_i = 1'b1;
        #1;
        checks++; if (bus.refill_qvalid_o !== 1'b1) begin failures++; $display("FAIL co_qvalid_hold got=%0h exp=1", bus.refill_qvalid_o); end
        step();
        bus.refill_qready_i = 1'b0;
        refill(2'd0);
        bus.rsp_ready_i = 1'b0;
        #1;
        checks++; if (bus.refill_qvalid_o !== 1'b0) begin failures++; $display("FAIL co_single_req got=%0h exp=0", bus.refill_qvalid_o); end
        checks++; if (bus.refill_pready_o !== 1'b0 || bus.write_valid_o !== 1'b0) begin failures++; $display("FAIL co_stall_pready got=%0h exp=0", bus.refill_pready_o); end
        bus.rsp_ready_i = 1'b1;
        #1;
        checks++; if (bus.refill_pready_o !== 1'b1) begin failures++; $display("FAIL co_pready got=%0h exp=1", bus.refill_pready_o); end
        checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 4'b0011) begin failures++; $display("FAIL co_rsp_id got=%0h exp=3", bus.rsp_id_o); end
        checks++; if (bus.rsp_data_o !== REF_DATA) begin failures++; $display("FAIL co_rsp_data got=%0h exp=%0h", bus.rsp_data_o, REF_DATA); end
        checks++; if (bus.write_valid_o !== 1'b1) begin failures++; $display("FAIL co_write_valid got=%0h exp=1", bus.write_valid_o); end
        checks++; if (bus.write_addr_o !== 6'h00) begin failures++; $display("FAIL co_write_addr got=%0h exp=0", bus.write_addr_o); end
        checks++; if (bus.write_tag_o !== 22'h8) begin failures++; $display("FAIL co_write_tag got=%0h exp=8", bus.write_tag_o); end
        checks++; if (bus.write_set_o !== 1'b0) begin failures++; $display("FAIL co_write_set got=%0h exp=0", bus.write_set_o); end
        step();
        idle();
        #1;
        checks++; if (bus.rsp_valid_o !== 1'b0) begin failures++; $display("FAIL co_single_rsp got=%0h exp=0", bus.rsp_valid_o); end
    endtask

    task automatic test_full();
        logic [FETCH_AW-1:0] a;
        do_reset();
        bus.refill_qready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 32'h3000 + FETCH_AW'(i * 16);
            miss(a, 4'b0001);
            #1;
            checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL full_alloc%0d got=%0h exp=1", i, bus.in_ready_o); end
            if (i > 0) begin
                checks++; if (bus.refill_qvalid_o !== 1'b1 || bus.refill_qaddr_o !== a - 32'h10 || bus.refill_qid_o !== PID_WIDTH'(i - 1)) begin
                    failures++; $display("FAIL full_req%0d got=%0h/%0h exp=%0h/%0h", i, bus.refill_qaddr_o, bus.refill_qid_o, a - 32'h10, i - 1); end
            end
            step();
        end
        miss(32'h3040, 4'b0001);
        #1;
        checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL full_stall got=%0h exp=0", bus.in_ready_o); end
        checks++; if (bus.refill_qaddr_o !== 32'h3030 || bus.refill_qid_o !== 2'd3) begin failures++; $display("FAIL full_req3 got=%0h exp=3030", bus.refill_qaddr_o); end
        step();
        #1;
        checks++; if (bus.in_ready_o !== 1'b0 || bus.refill_qvalid_o !== 1'b0) begin failures++; $display("FAIL full_stall2 got=%0h exp=0", bus.in_ready_o); end
        miss(32'h3014, 4'b0100);
        #1;
        checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL full_coalesce got=%0h exp=1", bus.in_ready_o); end
        step();
        miss(32'h3040, 4'b0001);
        refill(2'd2);
        #1;
        checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL full_freeing_excluded got=%0h exp=0", bus.in_ready_o); end
        checks++; if (bus.write_valid_o !== 1'b1 || bus.write_set_o !== 1'b0 || bus.write_addr_o !== 6'h02) begin failures++; $display("FAIL full_w0 got=%0h/%0h exp=0/2", bus.write_set_o, bus.write_addr_o); end
        checks++; if (bus.write_tag_o !== 22'hC || bus.rsp_id_o !== 4'b0001) begin failures++; $display("FAIL full_w0_tag got=%0h/%0h exp=c/1", bus.write_tag_o, bus.rsp_id_o); end
        step();
        bus.refill_pvalid_i = 1'b0;
        #1;
        checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL full_realloc got=%0h exp=1", bus.in_ready_o); end
        step();
        bus.in_valid_i = 1'b0;
        refill(2'd1);
        #1;
        checks++; if (bus.refill_qvalid_o !== 1'b1 || bus.refill_qaddr_o !== 32'h3040 || bus.refill_qid_o !== 2'd2) begin failures++; $display("FAIL full_req4 got=%0h/%0h exp=3040/2", bus.refill_qaddr_o, bus.refill_qid_o); end
        checks++; if (bus.rsp_id_o !== 4'b0101 || bus.write_set_o !== 1'b1 || bus.write_addr_o !== 6'h01) begin failures++; $display("FAIL full_w1 got=%0h/%0h/%0h exp=5/1/1", bus.rsp_id_o, bus.write_set_o, bus.write_addr_o); end
        step();
        refill(2'd0);
        #1;
        checks++; if (bus.write_valid_o !== 1'b1 || bus.write_set_o !== 1'b0 || bus.write_addr_o !== 6'h00) begin failures++; $display("FAIL full_w2 got=%0h/%0h exp=0/0", bus.write_set_o, bus.write_addr_o); end
        step();
        idle();
    endtask

    task automatic test_priority();
        do_reset();
        bus.refill_qready_i = 1'b1;
        miss(32'h4000, 4'b0001);
        step();
        bus.in_valid_i = 1'b0;
        step();
        refill(2'd0);
        bus.in_valid_i = 1'b1; bus.in_hit_i = 1'b1; bus.in_addr_i = 32'h5000;
        bus.in_id_i = 4'b0010; bus.in_data_i = HIT_DATA;
        #1;
        checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 4'b0001 || bus.rsp_data_o !== REF_DATA) begin failures++; $display("FAIL prio_refill got=%0h exp=1", bus.rsp_id_o); end
        checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL prio_hit_held got=%0h exp=0", bus.in_ready_o); end
        step();
        bus.refill_pvalid_i = 1'b0;
        #1;
        checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 4'b0010 || bus.rsp_data_o !== HIT_DATA) begin failures++; $display("FAIL prio_hit_next got=%0h exp=2", bus.rsp_id_o); end
        checks++; if (bus.in_ready_o !== 1'b1 || bus.write_valid_o !== 1'b0) begin failures++; $display("FAIL prio_hit_ready got=%0h exp=1", bus.in_ready_o); end
        step();
        idle();
    endtask

    task automatic test_error_stale();
        do_reset();
        miss(32'h7000, 4'b1000);
        step();
        do_reset();
        refill(2'd0);
        #1;
        checks++; if (bus.refill_pready_o !== 1'b1) begin failures++; $display("FAIL stale_pready got=%0h exp=1", bus.refill_pready_o); end
        checks++; if (bus.write_valid_o !== 1'b0 || bus.rsp_valid_o !== 1'b0) begin failures++; $display("FAIL stale_dropped got=%0h/%0h exp=0/0", bus.write_valid_o, bus.rsp_valid_o); end
        step();
        idle();
        bus.refill_qready_i = 1'b1;
        miss(32'h7000, 4'b1000);
        step();
        bus.in_valid_i = 1'b0;
        step();
        refill(2'd0);
        bus.refill_perror_i = 1'b1;
        #1;
        checks++; if (bus.write_error_o !== 1'b1 || bus.rsp_error_o !== 1'b1) begin failures++; $display("FAIL err_flags got=%0h/%0h exp=1/1", bus.write_error_o, bus.rsp_error_o); end
        checks++; if (bus.rsp_id_o !== 4'b1000 || bus.write_valid_o !== 1'b1) begin failures++; $display("FAIL err_rsp_id got=%0h exp=8", bus.rsp_id_o); end
        step();
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        bus.flush_valid_i = 1'b1;
        #1;
        checks++; if (bus.flush_ready_o !== 1'b1) begin failures++; $display("FAIL flush_idle got=%0h exp=1", bus.flush_ready_o); end
        miss(32'h6000, 4'b0001);
        step();
        bus.in_valid_i = 1'b0;
        #1;
        checks++; if (bus.flush_ready_o !== 1'b0) begin failures++; $display("FAIL flush_req_pending got=%0h exp=0", bus.flush_ready_o); end
        bus.refill_qready_i = 1'b1;
        step();
        bus.refill_qready_i = 1'b0;
        #1;
        checks++; if (bus.flush_ready_o !== 1'b0) begin failures++; $display("FAIL flush_entry_pending got=%0h exp=0", bus.flush_ready_o); end
        refill(2'd0);
        step();
        bus.refill_pvalid_i = 1'b0;
        #1;
        checks++; if (bus.flush_ready_o !== 1'b1) begin failures++; $display("FAIL flush_done got=%0h exp=1", bus.flush_ready_o); end
        idle();
    endtask

    initial begin
        test_reset();
        test_hit();
        test_coalesce();
        test_full();
        test_priority();
        test_error_stale();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
